// File: rtl/bitseq_pkg.sv
// rtl/bitseq_pkg.sv - shared FSM state type, default length and effective-value helpers
package bitseq_pkg;

    localparam int MAX_LEN_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_FIN
    } state_e;

    // A length of 0, or one longer than the register, selects the full register.
    function automatic int eff_len(input logic [3:0] len, input int max_len);
        if (len == 4'd0 || int'(len) > max_len) begin
            return max_len;
        end
        return int'(len);
    endfunction

    // A repeat count of 0 still sends the pattern once.
    function automatic logic [3:0] eff_repeat(input logic [3:0] rep);
        return (rep == 4'd0) ? 4'd1 : rep;
    endfunction

endpackage

// File: rtl/bitseq_shreg.sv
// rtl/bitseq_shreg.sv - loadable MSB-first shift register with remaining-bit counter
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture load_data; its MSB is emitted by the caller this cycle,
//                       so the register keeps load_data<<1 and counts load_len-1 bits left
//   shift               advance one bit; head moves to the next pattern bit
//   load_data, load_len pattern aligned to the MSB and its length in bits
//   head                next bit to emit (MSB of the register)
//   bits_left           bits still to emit after the one currently on the line
module bitseq_shreg #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_len,
    output logic          head,
    output logic [CW-1:0] bits_left
);

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = load_data << 1;
            cnt_d  = load_len - CW'(1);
        end else if (shift && cnt_q != '0) begin
            data_d = data_q << 1;
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head      = data_q[W-1];
    assign bits_left = cnt_q;

endmodule

// File: rtl/bit_pattern_tx.sv
// rtl/bit_pattern_tx.sv - serial pattern transmitter with repeat count and inter-pattern gap
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   START                            begin a run (only honoured in IDLE)
//   PATTERN, LEN, REPEAT, GAP        run settings, captured when START is accepted
//   X_OUT                            registered serial stream, MSB of the pattern first
//   BUSY                             high during pattern bits and gaps
//   DONE                             one-cycle pulse after the final bit
module bit_pattern_tx
    import bitseq_pkg::*;
#(
    parameter int   MAX_LEN    = MAX_LEN_DEFAULT,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [MAX_LEN-1:0] PATTERN,
    input  logic [3:0]         LEN,
    input  logic [3:0]         REPEAT,
    input  logic [3:0]         GAP,
    output logic               X_OUT,
    output logic               BUSY,
    output logic               DONE
);

    localparam int CW = $clog2(MAX_LEN) + 1;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;       // pattern left-aligned so bit LEN-1 is the MSB
    logic [CW-1:0]      len_q, len_d;
    logic [3:0]         rep_q, rep_d;       // transmissions still to start after the current one
    logic [3:0]         gap_q, gap_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               x_out_q, x_out_d;

    logic               sr_load, sr_shift;
    logic [MAX_LEN-1:0] sr_data;
    logic [CW-1:0]      sr_len;
    logic               sr_head;
    logic [CW-1:0]      sr_left;

    logic [CW-1:0]      in_len;
    logic [CW-1:0]      in_shamt;
    logic [MAX_LEN-1:0] in_pat;

    assign in_len   = CW'(eff_len(LEN, MAX_LEN));
    assign in_shamt = CW'(MAX_LEN) - in_len;
    assign in_pat   = PATTERN << in_shamt;

    bitseq_shreg #(
        .W  (MAX_LEN),
        .CW (CW)
    ) u_shreg (
        .clk       (CLK),
        .reset     (RESET),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (sr_data),
        .load_len  (sr_len),
        .head      (sr_head),
        .bits_left (sr_left)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        x_out_d   = IDLE_LEVEL;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_data   = pat_q;
        sr_len    = len_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    pat_d   = in_pat;
                    len_d   = in_len;
                    rep_d   = eff_repeat(REPEAT) - 4'd1;
                    gap_d   = GAP;
                    sr_load = 1'b1;
                    sr_data = in_pat;
                    sr_len  = in_len;
                    x_out_d = in_pat[MAX_LEN-1];
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sr_left != '0) begin
                    sr_shift = 1'b1;
                    x_out_d  = sr_head;
                end else if (rep_q != 4'd0) begin
                    if (gap_q != 4'd0) begin
                        gap_cnt_d = gap_q - 4'd1;
                        state_d   = ST_GAP;
                    end else begin
                        // Back-to-back: next transmission's first bit follows immediately.
                        sr_load = 1'b1;
                        x_out_d = pat_q[MAX_LEN-1];
                        rep_d   = rep_q - 4'd1;
                    end
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    sr_load = 1'b1;
                    x_out_d = pat_q[MAX_LEN-1];
                    rep_d   = rep_q - 4'd1;
                    state_d = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            x_out_q   <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            x_out_q   <= x_out_d;
        end
    end

    assign X_OUT = x_out_q;
    assign BUSY  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign DONE  = (state_q == ST_FIN);

endmodule

// File: tb/tb_bit_pattern_tx.sv
// tb/tb_bit_pattern_tx.sv - directed self-checking bench for bit_pattern_tx
module tb_bit_pattern_tx;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [7:0] PATTERN;
    logic [3:0] LEN;
    logic [3:0] REPEAT;
    logic [3:0] GAP;
    logic       X_OUT;
    logic       BUSY;
    logic       DONE;

    int total  = 0;
    int passed = 0;

    bit_pattern_tx #(
        .MAX_LEN    (8),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .PATTERN (PATTERN),
        .LEN     (LEN),
        .REPEAT  (REPEAT),
        .GAP     (GAP),
        .X_OUT   (X_OUT),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic start_run(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                             input logic [3:0] g, input logic hold);
        PATTERN = p;
        LEN     = l;
        REPEAT  = r;
        GAP     = g;
        START   = 1'b1;
        cyc();
        START   = hold;
    endtask

    // Cycle i+1 after the accepting edge is checked against bit n-1-i of each vector.
    // mode 1 scrambles START and the settings every cycle; mode 2 keeps START high.
    task automatic watch(input string name, input int n, input logic [15:0] ex,
                         input logic [15:0] eb, input logic [15:0] ed, input int mode);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s c%0d X_OUT", name, i + 1), X_OUT, ex[n-1-i]);
            chk($sformatf("%s c%0d BUSY",  name, i + 1), BUSY,  eb[n-1-i]);
            chk($sformatf("%s c%0d DONE",  name, i + 1), DONE,  ed[n-1-i]);
            if (mode == 1 && i < n - 1) begin
                START   = (i % 2 == 0);
                PATTERN = ~PATTERN;
                LEN     = 4'(i);
                REPEAT  = 4'(i);
                GAP     = 4'(i);
            end
            if (i == n - 1) START = 1'b0;
            cyc();
        end
    endtask

    task automatic idle_chk(input string name, input int k);
        for (int i = 0; i < k; i++) begin
            chk($sformatf("%s i%0d X_OUT", name, i), X_OUT, 1'b0);
            chk($sformatf("%s i%0d BUSY",  name, i), BUSY,  1'b0);
            chk($sformatf("%s i%0d DONE",  name, i), DONE,  1'b0);
            cyc();
        end
    endtask

    initial begin
        RESET   = 1'b1;
        START   = 1'b0;
        PATTERN = 8'h00;
        LEN     = 4'd0;
        REPEAT  = 4'd0;
        GAP     = 4'd0;
        cyc();
        cyc();
        idle_chk("reset", 1);
        START   = 1'b1;
        PATTERN = 8'hFF;
        cyc();
        idle_chk("reset over start", 1);
        RESET = 1'b0;
        START = 1'b0;
        cyc();

        start_run(8'h0B, 4'd4, 4'd1, 4'd0, 1'b0);
        watch("basic", 5, 16'b10110, 16'b11110, 16'b00001, 0);
        idle_chk("basic after", 1);

        start_run(8'h0B, 4'd4, 4'd2, 4'd3, 1'b0);
        watch("gap", 12, 16'b101100010110, 16'b111111111110, 16'b000000000001, 0);

        start_run(8'hA5, 4'd0, 4'd0, 4'd5, 1'b0);
        watch("defaults", 9, 16'b101001010, 16'b111111110, 16'b000000001, 0);

        start_run(8'h05, 4'd3, 4'd3, 4'd0, 1'b0);
        watch("b2b", 10, 16'b1011011010, 16'b1111111110, 16'b0000000001, 0);

        start_run(8'hC3, 4'd15, 4'd1, 4'd0, 1'b0);
        watch("len>max", 9, 16'b110000110, 16'b111111110, 16'b000000001, 0);

        start_run(8'h0B, 4'd4, 4'd2, 4'd1, 1'b0);
        watch("ignored", 10, 16'b1011010110, 16'b1111111110, 16'b0000000001, 1);
        idle_chk("ignored after", 3);

        start_run(8'h02, 4'd2, 4'd1, 4'd0, 1'b1);
        watch("held start", 7, 16'b1000100, 16'b1100110, 16'b0010001, 2);
        idle_chk("held after", 2);

        start_run(8'h0B, 4'd4, 4'd2, 4'd0, 1'b0);
        watch("abort pre", 2, 16'b10, 16'b11, 16'b00, 0);
        chk("abort bit3 X_OUT", X_OUT, 1'b1);
        chk("abort bit3 BUSY",  BUSY,  1'b1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        idle_chk("abort after", 4);

        start_run(8'h0B, 4'd4, 4'd1, 4'd0, 1'b0);
        watch("post reset", 5, 16'b10110, 16'b11110, 16'b00001, 0);
        idle_chk("post reset after", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bit_pattern_tx.md
BIT_PATTERN_TX -- requirements
Module: bit_pattern_tx

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits.
REQ-002 Parameter IDLE_LEVEL, default 1'b0, X_OUT level when no pattern bit is being sent.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RESET  input  1  reset; synchronous, active-high.
REQ-005 START  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 PATTERN  input  MAX_LEN  bits to send; PATTERN[LEN-1] is sent first, PATTERN[0] last.
REQ-007 LEN  input  4  pattern length; 0 or >MAX_LEN means MAX_LEN.
REQ-008 REPEAT  input  4  number of pattern transmissions; 0 means 1.
REQ-009 GAP  input  4  number of IDLE_LEVEL bits inserted between transmissions; 0 means back-to-back.
REQ-010 X_OUT  output  1  registered serial bit stream; the stimulus line for the sequence detector.
REQ-011 BUSY  output  1  high from the first pattern bit through the last pattern bit, including gaps.
REQ-012 DONE  output  1  one-cycle pulse in the cycle after the last bit.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT, GAP and FIN.
REQ-014 In IDLE with START=1, the block SHALL latch PATTERN, effective LEN, effective REPEAT and GAP, then enter SHIFT on the next edge.
REQ-015 X_OUT SHALL show the first pattern bit in the cycle after START is sampled, a fixed one-cycle latency.
REQ-016 SHIFT SHALL emit one bit per cycle, MSB-first from PATTERN[LEN-1] to PATTERN[0], using the latched copy only.
REQ-017 After the last bit of a transmission, if transmissions remain and GAP>0, the FSM SHALL enter GAP and drive IDLE_LEVEL for exactly GAP cycles, then return to SHIFT.
REQ-018 If transmissions remain and GAP=0, the next transmission's first bit SHALL follow the previous last bit in the very next cycle.
REQ-019 No gap SHALL follow the final transmission; after the final bit the FSM SHALL enter FIN for one cycle, then IDLE.
REQ-020 In FIN, the block SHALL drive DONE=1, BUSY=0 and X_OUT=IDLE_LEVEL.
REQ-021 BUSY SHALL be 1 in SHIFT and GAP and 0 in IDLE and FIN.
REQ-022 Busy duration SHALL be exactly LEN*REPEAT + GAP*(REPEAT-1) cycles, using effective values.
REQ-023 START SHALL be ignored in SHIFT, GAP and FIN.
REQ-024 START held high continuously SHALL start a new transmission on the IDLE cycle following FIN, giving one idle cycle between runs.
REQ-025 Changes on PATTERN, LEN, REPEAT or GAP while BUSY SHALL have no effect on the run in progress.
REQ-026 The bit counter SHALL be clog2(MAX_LEN)+1 bits wide, and the repeat and gap counters 4 bits each, with no wrap-around inside a run.

Reset
REQ-027 RESET=1 at an edge SHALL force IDLE, X_OUT=IDLE_LEVEL, BUSY=0, DONE=0 and clear all counters, with priority over START and mid-run activity.
REQ-028 Reset mid-run SHALL abort the run with no DONE pulse; the first START after RESET deasserts SHALL behave as from power-up.

Structure
REQ-029 Package bitseq_pkg SHALL hold the FSM state enum, MAX_LEN_DEFAULT=8 and the effective-value helper functions for LEN and REPEAT.
REQ-030 One sub-module, bitseq_shreg (loadable MSB-first shift register with a bit counter), SHALL be instantiated in bit_pattern_tx; the FSM and counters stay in the top level.

Verification
REQ-031 Basic run: PATTERN=8'h0B, LEN=4, REPEAT=1, GAP=0, START for one cycle -> X_OUT=1,0,1,1 on cycles 1-4, BUSY high for 4 cycles, DONE on cycle 5.
REQ-032 Repeat with gap: PATTERN=8'h0B, LEN=4, REPEAT=2, GAP=3 -> X_OUT=1011 000 1011, 11 BUSY cycles, a single DONE.
REQ-033 Defaults and back-to-back: LEN=0, REPEAT=0, PATTERN=8'hA5 -> 8 bits 10100101 then DONE; with LEN=3, REPEAT=3, GAP=0 and PATTERN=8'h05 -> 101101101.
REQ-034 Ignored inputs: START pulses and a PATTERN change mid-run -> output stream identical to an undisturbed run, and no second run starts.
REQ-035 Reset mid-run: RESET for one cycle during bit 3 of REPEAT=2 -> next cycle X_OUT=0, BUSY=0, no DONE; a following START gives a clean full run.
REQ-036 Loopback: connect X_OUT to the sequence detector's X and send its target pattern -> Z_OUT asserts once per transmission, at the cycle count the detector spec defines.
